clk_sel_ctrl: RTL and testbench

Synchronous controller that owns the select input of the glitch-free clock mux (`clk_mux`). It accepts clock-switch requests from several requesters, arbitrates them round-robin, drives the mux select, then waits a fixed settle window covering the mux's synchronizer and handover latency before reporting completion. A minimum dwell time between switches prevents select thrash. The block runs on an always-on control clock, and the mux treats `sel_o` as asynchronous.

---
 rtl/clk_sel_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_sel_ctrl
//  Description : Owns the select of the glitch-free clock mux. Requests from
//                several requesters are arbitrated round-robin. Each accepted
//                switch drives a new select and waits a settle window. A dwell
//                window then blocks further switches.
//                Optional feature macro: CLK_SEL_CTRL_SKIP_SAME_EN. When it is
//                defined, a request for the select already driven completes
//                at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_sel_ctrl #(
    parameter int  NUM_INPUTS    = 4,
    parameter int  NUM_REQ       = 2,
    parameter int  SETTLE_CYCLES = 16,
    parameter int  DWELL_CYCLES  = 8,
    parameter int  RESET_SEL     = 0,
    localparam int SELW          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*SELW-1:0] req_sel_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [NUM_REQ-1:0]      err_o,
    output logic [SELW-1:0]         sel_o,
    output logic                    busy_o
);

    localparam int c_ptrw    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_max = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int c_cntw    = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [c_cntw-1:0]   cnt_q,    cnt_d;
    logic [SELW-1:0]     sel_q,    sel_d;
    logic [c_ptrw-1:0]   gnt_q,    gnt_d;
    logic [c_ptrw-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  done_q,   done_d;
    logic                busy_q,   busy_d;

    logic                w_found;
    logic [c_ptrw-1:0]   w_pick_idx;
    logic [SELW-1:0]     w_pick_sel;
    logic                w_tgt_ok;
    logic                w_arb;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [NUM_REQ-1:0]  w_gnt_onehot;
    int                  w_j;
`ifdef CLK_SEL_CTRL_SKIP_SAME_EN
    logic [NUM_REQ-1:0]  w_skip_done;
`endif

    // Round-robin search starting at the pointer, wrapping once over all requesters
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_j        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = int'(rr_ptr_q) + i;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && req_valid_i[w_j]) begin
                w_found    = 1'b1;
                w_pick_idx = c_ptrw'(w_j);
            end
        end
    end

    // Target decode and handshake responses; only an idle, out-of-reset controller arbitrates
    always_comb begin
        w_pick_sel    = req_sel_i[int'(w_pick_idx)*SELW +: SELW];
        w_tgt_ok      = (int'(w_pick_sel) < NUM_INPUTS);
        w_arb         = (state_q == ST_IDLE) && !rst_i && w_found;
        w_pick_onehot = NUM_REQ'(1) << w_pick_idx;
        w_gnt_onehot  = NUM_REQ'(1) << gnt_q;
        req_ready_o   = w_arb ? w_pick_onehot : '0;
        err_o         = (w_arb && !w_tgt_ok) ? w_pick_onehot : '0;
    end

    // Next-state logic: grant/latch in IDLE, count down settle then dwell
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
`ifdef CLK_SEL_CTRL_SKIP_SAME_EN
        w_skip_done = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_arb) begin
                    // Any response, error or grant, moves the search past this requester
                    if (int'(w_pick_idx) == NUM_REQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = w_pick_idx + c_ptrw'(1);
                    end
`ifdef CLK_SEL_CTRL_SKIP_SAME_EN
                    if (w_tgt_ok && (w_pick_sel == sel_q)) begin
                        w_skip_done = w_pick_onehot;
                    end else
`endif
                    if (w_tgt_ok) begin
                        sel_d   = w_pick_sel;
                        gnt_d   = w_pick_idx;
                        cnt_d   = c_cntw'(SETTLE_CYCLES - 1);
                        state_d = ST_SETTLE;
                        // A one-cycle settle window finishes in the cycle right after accept
                        if (SETTLE_CYCLES == 1) begin
                            done_d = w_pick_onehot;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    if (DWELL_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DWELL;
                        cnt_d   = c_cntw'(DWELL_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - c_cntw'(1);
                    // done is registered, so it is launched one cycle before the last settle cycle
                    if (cnt_q == c_cntw'(1)) begin
                        done_d = w_gnt_onehot;
                    end
                end
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cntw'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, select and pulse registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= SELW'(RESET_SEL);
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign sel_o  = sel_q;
    assign busy_o = busy_q;
`ifdef CLK_SEL_CTRL_SKIP_SAME_EN
    assign done_o = done_q | w_skip_done;
`else
    assign done_o = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_sel_ctrl
//  Description : Scoreboard bench for clk_sel_ctrl. A timestamp-based reference
//                model queues the expected handshake, select and busy
//                behaviour. A negedge monitor compares it with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_sel_ctrl;

    localparam int c_ni = 3;
    localparam int c_nr = 2;
    localparam int c_s  = 16;
    localparam int c_d  = 8;
    localparam int c_rs = 0;
    localparam int c_sw = 2;

    typedef struct {
        int         cyc;
        logic [1:0] rdy;
        logic [1:0] err;
        logic [1:0] dn;
    } ev_t;

    typedef struct {
        int   cyc;
        int   sel;
        logic busy;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] req_valid_i = '0;
    logic [3:0] req_sel_i = '0;
    logic [1:0] req_ready_o;
    logic [1:0] done_o;
    logic [1:0] err_o;
    logic [1:0] sel_o;
    logic       busy_o;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    ev_t ev_q[$];
    st_t stat_q[$];

    // reference model state: plain timestamps, no FSM
    int         m_sel = c_rs;
    int         m_ptr = 0;
    int         free_at = 0;
    int         busy_from = 1;
    int         busy_to = 0;
    logic [1:0] g_mask = '0;

    // stimulus variables
    logic       d_rst = 1'b1;
    logic [1:0] d_valid = '0;
    logic [3:0] d_sel = '0;

    clk_sel_ctrl #(
        .NUM_INPUTS    (c_ni),
        .NUM_REQ       (c_nr),
        .SETTLE_CYCLES (c_s),
        .DWELL_CYCLES  (c_d),
        .RESET_SEL     (c_rs)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_sel_i   (req_sel_i),
        .req_ready_o (req_ready_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .sel_o       (sel_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected behaviour of the current cycle from the request timing rules
    task automatic model_step();
        st_t s;
        ev_t e;
        ev_t e2;
        int  r;
        int  t;
        s.cyc  = cyc;
        s.sel  = m_sel;
        s.busy = (cyc >= busy_from) && (cyc <= busy_to);
        stat_q.push_back(s);
        g_mask = '0;
        if (rst_i) begin
            while (ev_q.size() > 0 && ev_q[$].cyc > cyc) void'(ev_q.pop_back());
            m_sel     = c_rs;
            m_ptr     = 0;
            free_at   = cyc + 1;
            busy_from = 1;
            busy_to   = 0;
        end else if (cyc >= free_at && req_valid_i != 2'b00) begin
            r = -1;
            for (int k = 0; k < c_nr; k++) begin
                int j;
                j = (m_ptr + k) % c_nr;
                if (r < 0 && req_valid_i[j]) r = j;
            end
            t = int'(req_sel_i[r*c_sw +: c_sw]);
            g_mask[r] = 1'b1;
            m_ptr = (r + 1) % c_nr;
            e.cyc = cyc;
            e.rdy = g_mask;
            e.err = '0;
            e.dn  = '0;
            if (t >= c_ni) begin
                e.err = g_mask;
                ev_q.push_back(e);
            end
`ifdef CLK_SEL_CTRL_SKIP_SAME_EN
            else if (t == m_sel) begin
                e.dn = g_mask;
                ev_q.push_back(e);
            end
`endif
            else begin
                ev_q.push_back(e);
                e2.cyc = cyc + c_s;
                e2.rdy = '0;
                e2.err = '0;
                e2.dn  = g_mask;
                ev_q.push_back(e2);
                m_sel     = t;
                busy_from = cyc + 1;
                busy_to   = cyc + c_s + c_d;
                free_at   = cyc + c_s + c_d + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst_i       = d_rst;
        req_valid_i = d_valid;
        req_sel_i   = d_sel;
        #1;
        model_step();
        mon_en = 1'b1;
    endtask

    // Raise a request and hold it until the model grants it (bounded)
    task automatic request(input int r, input int s);
        int k;
        d_valid[r] = 1'b1;
        d_sel[r*c_sw +: c_sw] = 2'(s);
        k = 0;
        do begin
            step();
            k++;
        end while (!g_mask[r] && k < 200);
        if (!g_mask[r]) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout requester=%0d no grant after %0d cycles, required a grant", r, k);
        end
        d_valid[r] = 1'b0;
    endtask

    // Monitor: per-cycle status plus handshake events popped from the scoreboard
    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (mon_en) begin
            if (stat_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL status_queue cyc=%0d empty, required an entry", cyc);
            end else begin
                s = stat_q.pop_front();
                checks++;
                if (s.cyc != cyc || sel_o !== 2'(s.sel) || busy_o !== s.busy) begin
                    failures++;
                    $display("FAIL status cyc=%0d sel_o=%0d busy_o=%b, required sel=%0d busy=%b (entry cyc %0d)",
                             cyc, sel_o, busy_o, s.sel, s.busy, s.cyc);
                end
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event cyc=%0d saw nothing, required ready=%b err=%b done=%b",
                         e.cyc, e.rdy, e.err, e.dn);
            end
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e = ev_q.pop_front();
                checks++;
                if (req_ready_o !== e.rdy || err_o !== e.err || done_o !== e.dn) begin
                    failures++;
                    $display("FAIL event cyc=%0d ready=%b err=%b done=%b, required ready=%b err=%b done=%b",
                             cyc, req_ready_o, err_o, done_o, e.rdy, e.err, e.dn);
                end
            end else if ((req_ready_o | err_o | done_o) !== 2'b00) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d ready=%b err=%b done=%b, required all 0",
                         cyc, req_ready_o, err_o, done_o);
            end
        end
    end

    initial begin
        int k;
        // reset held with both requesters valid
        d_rst   = 1'b1;
        d_valid = 2'b11;
        d_sel   = {2'd2, 2'd1};
        repeat (5) step();
        d_rst   = 1'b0;
        d_valid = 2'b00;
        step();

        // single switch
        request(0, 2);
        repeat (30) step();

        // arbitration with both requesters continuously valid
        d_valid = 2'b11;
        d_sel   = {2'd2, 2'd1};
        repeat (80) step();
        d_valid = 2'b00;
        repeat (30) step();

        // invalid target
        request(1, 3);
        repeat (3) step();

        // reset mid-operation, then a fresh request
        request(0, 1);
        repeat (4) step();
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        request(1, 2);
        repeat (30) step();

        // same-target request
        request(1, 2);
        repeat (30) step();

        // randomized traffic with occasional resets
        repeat (1500) begin
            for (int r = 0; r < c_nr; r++) begin
                if (d_valid[r] && g_mask[r]) begin
                    d_valid[r] = 1'b0;
                end else if (d_valid[r] && $urandom_range(0, 19) == 0) begin
                    d_valid[r] = 1'b0;
                end else if (!d_valid[r] && $urandom_range(0, 2) == 0) begin
                    d_valid[r] = 1'b1;
                    d_sel[r*c_sw +: c_sw] = 2'($urandom_range(0, 3));
                end
            end
            d_rst = ($urandom_range(0, 399) == 0);
            step();
        end

        // drain outstanding completions
        d_rst   = 1'b0;
        d_valid = 2'b00;
        k = 0;
        while (ev_q.size() > 0 && k < 100) begin
            step();
            k++;
        end
        step();
        @(negedge clk);
        #1;
        if (ev_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain %0d events still pending, required 0", ev_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
